// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier sequencer: datapath strobe bundle,
// FSM state encoding and the Booth recoding helper.
package booth_pkg;

    typedef struct packed {
        logic load_A;
        logic load_B;
        logic load_add;
        logic shift_HQ_LQ_Q_1;
        logic add_sub;
    } mult_control_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    localparam mult_control_t MULT_CTRL_IDLE = '{
        load_A:          1'b0,
        load_B:          1'b0,
        load_add:        1'b0,
        shift_HQ_LQ_Q_1: 1'b0,
        add_sub:         1'b0
    };

    // Booth recoding of {Q_0, Q_1}; returns {load_add, add_sub}
    function automatic logic [1:0] booth_decode(input logic q_0, input logic q_1);
        logic [1:0] res;
        case ({q_0, q_1})
            2'b10:   res = 2'b11;
            2'b01:   res = 2'b10;
            default: res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/booth_mult_sequencer_if.sv
// Handshake and datapath-control bundle between the Booth sequencer (slave view)
// and its operand source / consumer / datapath (master view).
interface booth_mult_sequencer_if;
    import booth_pkg::*;

    logic          valid;
    logic          ready;
    logic          Q_0;
    logic          Q_1;
    mult_control_t mult_control;
    logic          busy;
    logic          done_valid;
    logic          done_ready;
    logic [2:0]    state;

    modport slave (
        input  valid,
        input  Q_0,
        input  Q_1,
        input  done_ready,
        output ready,
        output mult_control,
        output busy,
        output done_valid,
        output state
    );

    modport master (
        output valid,
        output Q_0,
        output Q_1,
        output done_ready,
        input  ready,
        input  mult_control,
        input  busy,
        input  done_valid,
        input  state
    );

endinterface

// File: rtl/booth_mult_sequencer_iter.sv
// Booth iteration counter: loads N, decrements once per shift, flags the last iteration.
module booth_iter_counter #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    logic [CNT_W-1:0] cnt_r;

    // Iteration count register; the non-zero guard keeps it from wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= CNT_W'(N);
        end else if (dec && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/booth_mult_sequencer.sv
// Cycle-level controller for a radix-2 Booth multiplier datapath: accepts a request,
// loads operands, runs N add/sub + shift iterations and holds the result until acknowledged.
module booth_mult_sequencer
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    booth_mult_sequencer_if.slave         bus
);

    localparam int CNT_W = $clog2(N + 1);

    seq_state_e    state_r;
    seq_state_e    state_nxt_s;
    mult_control_t ctrl_s;
    logic          ready_s;
    logic          busy_s;
    logic          done_valid_s;
    logic          cnt_load_s;
    logic          cnt_dec_s;
    logic          cnt_last_s;

    assign cnt_load_s = (state_r == LOAD);
    assign cnt_dec_s  = (state_r == SHIFT);

    booth_iter_counter #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load_s),
        .dec  (cnt_dec_s),
        .last (cnt_last_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; DONE->IDLE never accepts, so a new request needs one IDLE cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.valid) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD:  state_nxt_s = EVAL;
            EVAL:  state_nxt_s = SHIFT;
            SHIFT: begin
                if (cnt_last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = EVAL;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode; only EVAL looks at the Booth bits
    always_comb begin
        ctrl_s       = MULT_CTRL_IDLE;
        ready_s      = 1'b0;
        busy_s       = 1'b0;
        done_valid_s = 1'b0;
        case (state_r)
            IDLE: ready_s = 1'b1;
            LOAD: begin
                ctrl_s.load_A = 1'b1;
                ctrl_s.load_B = 1'b1;
                busy_s        = 1'b1;
            end
            EVAL: begin
                {ctrl_s.load_add, ctrl_s.add_sub} = booth_decode(bus.Q_0, bus.Q_1);
                busy_s = 1'b1;
            end
            SHIFT: begin
                ctrl_s.shift_HQ_LQ_Q_1 = 1'b1;
                busy_s                 = 1'b1;
            end
            DONE:    done_valid_s = 1'b1;
            default: ctrl_s       = MULT_CTRL_IDLE;
        endcase
    end

    assign bus.mult_control = ctrl_s;
    assign bus.ready        = ready_s;
    assign bus.busy         = busy_s;
    assign bus.done_valid   = done_valid_s;
    assign bus.state        = state_r;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Self-checking bench for booth_mult_sequencer: N=8 instance with a behavioural Booth
// datapath closing the loop, plus an N=4 instance for the parameterised latency.
module tb_booth_mult_sequencer;
    import booth_pkg::*;

    localparam int NB = 8;
    localparam int NS = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    booth_mult_sequencer_if bus  ();
    booth_mult_sequencer_if bus4 ();

    booth_mult_sequencer #(.N(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    booth_mult_sequencer #(.N(NS)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural Booth datapath around the N=8 instance
    logic              dp_en;
    logic              q0_f;
    logic              q1_f;
    logic signed [7:0] op_a;
    logic signed [7:0] op_b;
    logic signed [7:0] m_reg;
    logic signed [7:0] hq;
    logic [7:0]        lq;
    logic              q1r;

    assign bus.Q_0 = dp_en ? lq[0] : q0_f;
    assign bus.Q_1 = dp_en ? q1r   : q1_f;

    always @(posedge clk) begin
        if (bus.mult_control.load_A) begin
            m_reg <= op_a;
            hq    <= 8'sd0;
            lq    <= op_b;
            q1r   <= 1'b0;
        end else if (bus.mult_control.load_add) begin
            hq <= bus.mult_control.add_sub ? (hq - m_reg) : (hq + m_reg);
        end else if (bus.mult_control.shift_HQ_LQ_Q_1) begin
            {hq, lq, q1r} <= {hq[7], hq, lq};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requests one N=8 operation and observes it until done_valid (bounded)
    task automatic run8(input logic hold_valid, output int lat, output int shifts,
                        output int loads, output int viol);
        mult_control_t mc;
        bus.valid      = 1'b1;
        bus.done_ready = 1'b0;
        tick();
        lat = 0; shifts = 0; loads = 0; viol = 0;
        if (!hold_valid) bus.valid = 1'b0;
        while (!bus.done_valid && lat < 100) begin
            mc = bus.mult_control;
            if (mc.load_A && mc.load_B) loads++;
            if (mc.shift_HQ_LQ_Q_1) shifts++;
            if ((int'(mc.load_A | mc.load_B) + int'(mc.load_add) + int'(mc.shift_HQ_LQ_Q_1)) > 1) viol++;
            if (mc.add_sub && !mc.load_add) viol++;
            if (bus.busy !== (lat <= 2 * NB)) viol++;
            if (bus.ready !== 1'b0) viol++;
            tick();
            lat++;
        end
    endtask

    task automatic ack8();
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.state !== 3'd0 || bus.mult_control !== 5'b0 || bus.busy !== 1'b0 ||
            bus.done_valid !== 1'b0 || bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d ctrl=%b busy=%b dv=%b ready=%b, expected 0/00000/0/0/1",
                     bus.state, bus.mult_control, bus.busy, bus.done_valid, bus.ready);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.state !== 3'd0 || bus.ready !== 1'b1 || bus4.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: state=%0d ready=%b ready4=%b, expected 0/1/1",
                     bus.state, bus.ready, bus4.ready);
        end
    endtask

    task automatic test_handshake();
        int lim;
        bus.valid = 1'b1;
        tick();
        bus.valid = 1'b0;
        n_checks++;
        if (bus.mult_control !== 5'b11000 || bus.busy !== 1'b1 || bus.ready !== 1'b0 || bus.state !== 3'd1) begin
            n_fail++;
            $display("FAIL load_pulse: ctrl=%b busy=%b ready=%b state=%0d, expected 11000/1/0/1",
                     bus.mult_control, bus.busy, bus.ready, bus.state);
        end
        tick();
        n_checks++;
        if (bus.mult_control.load_A !== 1'b0 || bus.mult_control.load_B !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_single: load_A=%b load_B=%b busy=%b, expected 0/0/1",
                     bus.mult_control.load_A, bus.mult_control.load_B, bus.busy);
        end
        lim = 0;
        while (!bus.done_valid && lim < 100) begin
            tick();
            lim++;
        end
        n_checks++;
        if (bus.done_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_done: done_valid=%b after %0d cycles, expected 1", bus.done_valid, lim);
        end
        ack8();
    endtask

    task automatic test_latency();
        int lat, shifts, loads, viol;
        run8(1'b0, lat, shifts, loads, viol);
        n_checks++;
        if (lat !== 2 * NB + 1 || shifts !== NB || loads !== 1 || viol !== 0) begin
            n_fail++;
            $display("FAIL latency8: edges=%0d shifts=%0d loads=%0d viol=%0d, expected %0d/%0d/1/0",
                     lat, shifts, loads, viol, 2 * NB + 1, NB);
        end
        ack8();
    endtask

    task automatic test_decode();
        logic [1:0] pats [4];
        logic [1:0] pat;
        logic       exp_add;
        logic       exp_sub;
        int         k;
        int         lim;
        pats = '{2'b10, 2'b01, 2'b00, 2'b11};
        dp_en     = 1'b0;
        bus.valid = 1'b1;
        tick();
        bus.valid = 1'b0;
        k = 0; lim = 0;
        while (!bus.done_valid && lim < 100) begin
            if (bus.state === 3'd2) begin
                pat = (k < 4) ? pats[k] : 2'($urandom_range(0, 3));
                q0_f = pat[1];
                q1_f = pat[0];
                #1;
                exp_add = (pat == 2'b10) || (pat == 2'b01);
                exp_sub = (pat == 2'b10);
                n_checks++;
                if (bus.mult_control.load_add !== exp_add || bus.mult_control.add_sub !== exp_sub) begin
                    n_fail++;
                    $display("FAIL decode_%b: load_add=%b add_sub=%b, expected %b/%b",
                             pat, bus.mult_control.load_add, bus.mult_control.add_sub, exp_add, exp_sub);
                end
                k++;
            end
            tick();
            lim++;
        end
        n_checks++;
        if (k !== NB) begin
            n_fail++;
            $display("FAIL decode_evals: %0d EVAL cycles, expected %0d", k, NB);
        end
        ack8();
        dp_en = 1'b1;
    endtask

    task automatic test_datapath();
        int lat, shifts, loads, viol;
        int expected;
        logic signed [15:0] prod;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                op_a = 8'sd7;
                op_b = -8'sd3;
            end else begin
                op_a = 8'($urandom_range(0, 254) - 127);
                op_b = 8'($urandom_range(0, 255));
            end
            expected = int'(op_a) * int'(op_b);
            run8(1'b0, lat, shifts, loads, viol);
            prod = {hq, lq};
            n_checks++;
            if (int'(prod) !== expected || lat !== 2 * NB + 1) begin
                n_fail++;
                $display("FAIL product: %0d*%0d gave %0d (edges=%0d), expected %0d (edges=%0d)",
                         op_a, op_b, prod, lat, expected, 2 * NB + 1);
            end
            ack8();
        end
    endtask

    task automatic test_backpressure();
        int lat, shifts, loads, viol;
        int bad;
        run8(1'b0, lat, shifts, loads, viol);
        bus.valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done_valid !== 1'b1 || bus.state !== 3'd4 || bus.mult_control !== 5'b0 ||
                bus.ready !== 1'b0 || bus.busy !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d bad cycles of 10, expected 0 (last state=%0d dv=%b)",
                     bad, bus.state, bus.done_valid);
        end
        bus.valid = 1'b0;
        ack8();
        n_checks++;
        if (bus.state !== 3'd0 || bus.done_valid !== 1'b0 || bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: state=%0d dv=%b ready=%b, expected 0/0/1",
                     bus.state, bus.done_valid, bus.ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat, shifts, loads, viol;
        run8(1'b1, lat, shifts, loads, viol);
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        n_checks++;
        if (bus.state !== 3'd0 || bus.mult_control.load_A !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_bypass: state=%0d load_A=%b, expected 0/0",
                     bus.state, bus.mult_control.load_A);
        end
        tick();
        bus.valid = 1'b0;
        n_checks++;
        if (bus.state !== 3'd1 || bus.mult_control.load_A !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_load: state=%0d load_A=%b, expected 1/1",
                     bus.state, bus.mult_control.load_A);
        end
        lat = 0;
        while (!bus.done_valid && lat < 100) begin
            tick();
            lat++;
        end
        ack8();
    endtask

    task automatic test_reset_mid();
        int lim;
        int bad;
        bus.valid = 1'b1;
        tick();
        bus.valid = 1'b0;
        tick();
        tick();
        tick();
        lim = 0;
        while (bus.state !== 3'd2 && lim < 20) begin
            tick();
            lim++;
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.state !== 3'd0 || bus.mult_control !== 5'b0 || bus.ready !== 1'b1 ||
            bus.done_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: state=%0d ctrl=%b ready=%b dv=%b busy=%b, expected 0/00000/1/0/0",
                     bus.state, bus.mult_control, bus.ready, bus.done_valid, bus.busy);
        end
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mult_control !== 5'b0 || bus.state !== 3'd0 || bus.done_valid !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: %0d cycles with activity, expected 0", bad);
        end
    endtask

    task automatic test_n4();
        int lat, shifts, loads;
        bus4.valid      = 1'b1;
        bus4.done_ready = 1'b0;
        tick();
        bus4.valid = 1'b0;
        lat = 0; shifts = 0; loads = 0;
        while (!bus4.done_valid && lat < 100) begin
            bus4.Q_0 = 1'($urandom_range(0, 1));
            bus4.Q_1 = 1'($urandom_range(0, 1));
            #1;
            if (bus4.mult_control.load_A) loads++;
            if (bus4.mult_control.shift_HQ_LQ_Q_1) shifts++;
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 2 * NS + 1 || shifts !== NS || loads !== 1) begin
            n_fail++;
            $display("FAIL latency4: edges=%0d shifts=%0d loads=%0d, expected %0d/%0d/1",
                     lat, shifts, loads, 2 * NS + 1, NS);
        end
        bus4.done_ready = 1'b1;
        tick();
        bus4.done_ready = 1'b0;
        n_checks++;
        if (bus4.state !== 3'd0 || bus4.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL n4_return: state=%0d ready=%b, expected 0/1", bus4.state, bus4.ready);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        dp_en           = 1'b1;
        q0_f            = 1'b0;
        q1_f            = 1'b0;
        op_a            = 8'sd0;
        op_b            = 8'sd0;
        bus.valid       = 1'b0;
        bus.done_ready  = 1'b0;
        bus4.valid      = 1'b0;
        bus4.done_ready = 1'b0;
        bus4.Q_0        = 1'b0;
        bus4.Q_1        = 1'b0;
        test_reset();
        test_handshake();
        test_latency();
        test_decode();
        test_datapath();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_n4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
